arb_req: RTL

ARB_REQ -- requirements
Module: arb_req

---
 rtl/arb_req.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/arb_req.sv
// arb_req: burst requester in front of a round-robin arbiter.
//
// A one-cycle start pulse in IDLE captures a burst length (len+1 beats) and
// raises req. Once the arbiter grants (ack), each granted cycle in XFER
// transfers one beat; a withdrawn grant stalls the burst without losing
// position. After the last beat req drops, done pulses, and the block waits
// in REL for the grant to fall before returning to IDLE.
//
// Optional feature (macro ARB_REQ_TIMEOUT_EN): a grant-wait timeout in REQ.
// TO_CYC consecutive ungranted REQ cycles drop req, pulse err and go to REL.
// Without the macro, REQ waits indefinitely and err is tied low.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   start     burst request pulse, sampled only in IDLE
//   len       burst length minus one, captured on accepted start
//   ack       grant from the arbiter
//   req       registered request to the arbiter
//   beat      high for each transferred beat
//   beat_cnt  0-based index of the current beat
//   busy      high in every state except IDLE
//   done      one-cycle pulse after the last beat
//   err       one-cycle pulse on grant timeout (0 without the macro)

module arb_req #(
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned TO_CYC = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             ack,
  output logic             req,
  output logic             beat,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StRel} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  // Index the next granted beat will carry; saturates at len_q.
  logic [LEN_W-1:0] nxt_q, nxt_d;
  // Last beat has been transferred; next XFER cycle closes the burst.
  logic             fin_q, fin_d;
  logic             req_q, req_d;
  logic             beat_q, beat_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int unsigned ToW = (TO_CYC < 2) ? 1 : $clog2(TO_CYC);
  logic [ToW-1:0] to_q, to_d;
  logic           err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    nxt_d   = nxt_q;
    fin_d   = fin_q;
    req_d   = req_q;
    beat_d  = 1'b0;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
    to_d    = to_q;
    err_d   = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          len_d   = len;
          nxt_d   = '0;
          fin_d   = 1'b0;
          cnt_d   = '0;
          req_d   = 1'b1;
          busy_d  = 1'b1;
`ifdef ARB_REQ_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end

      StReq: begin
        if (ack) begin
          state_d = StXfer;
        end
`ifdef ARB_REQ_TIMEOUT_EN
        else if (to_q == ToW'(TO_CYC - 1)) begin
          state_d = StRel;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end

      StXfer: begin
        if (fin_q) begin
          state_d = StRel;
          fin_d   = 1'b0;
          req_d   = 1'b0;
          done_d  = 1'b1;
        end else if (ack) begin
          beat_d = 1'b1;
          cnt_d  = nxt_q;
          // Hold the index on the last beat so the counter never wraps.
          if (nxt_q == len_q) begin
            fin_d = 1'b1;
          end else begin
            nxt_d = nxt_q + 1'b1;
          end
        end
      end

      StRel: begin
        if (!ack) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      nxt_q   <= '0;
      fin_q   <= 1'b0;
      req_q   <= 1'b0;
      beat_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      nxt_q   <= nxt_d;
      fin_q   <= fin_d;
      req_q   <= req_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  // TO_CYC only matters with the timeout feature.
  logic unused_to_cyc;
  assign unused_to_cyc = ^TO_CYC;
  assign err           = 1'b0;
`endif

  assign req      = req_q;
  assign beat     = beat_q;
  assign beat_cnt = cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
